shift_seq: RTL and testbench
============================

SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: datapath width; power of two, at least 4; CW = $clog2(WIDTH).
REQ-002 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1: reset; synchronous, active-high.
REQ-004 SHALL have port start  input  1: request a new operation; sampled on the rising edge.
REQ-005 SHALL have port mode  input  2: operation select; 00 SHL fill 0, 01 SHR fill 0, 10 ROL through carry, 11 ROR through carry.
REQ-006 SHALL have port count  input  CW: number of single-bit steps, 0..WIDTH-1.
REQ-007 SHALL have port in  input  WIDTH: operand.
REQ-008 SHALL have port carry_in  input  1: initial carry.
REQ-009 SHALL have port out  output  WIDTH: working/result register.
REQ-010 SHALL have port carry_out  output  1: working/result carry register.
REQ-011 SHALL have port busy  output  1: high while in SHIFT.
REQ-012 SHALL have port done  output  1: high for exactly one cycle when the result is valid.

Function
REQ-013 SHALL implement the states IDLE, SHIFT and DONE; busy = (state==SHIFT) and done = (state==DONE), both decoded from registered state.
REQ-014 SHALL accept start only in IDLE or DONE; on acceptance SHALL load out<=in, carry_out<=carry_in, latch mode and a remaining counter<=count.
REQ-015 On acceptance with count==0, SHALL go to DONE; otherwise SHALL go to SHIFT.
REQ-016 In SHIFT, SHALL perform one step per edge and decrement remaining; when remaining==1, SHALL go to DONE after that step.
REQ-017 SHL step SHALL be carry_out<=out[WIDTH-1], out<={out[WIDTH-2:0],0}.
REQ-018 SHR step SHALL be carry_out<=out[0], out<={0,out[WIDTH-1:1]}.
REQ-019 ROL step SHALL be carry_out<=out[WIDTH-1], out<={out[WIDTH-2:0],carry_out}.
REQ-020 ROR step SHALL be carry_out<=out[0], out<={carry_out,out[WIDTH-1:1]}.
REQ-021 Latency: with start accepted at edge 0 and count=N, done SHALL be high in the cycle following edge N; N=0 and N=1 give done after edge 0 and edge 1 respectively.
REQ-022 DONE with no start SHALL go to IDLE next edge; DONE with start SHALL accept the new operation (back-to-back, no idle cycle).
REQ-023 start while in SHIFT SHALL be ignored; latched mode and remaining SHALL be unaffected by input changes after acceptance.
REQ-024 out and carry_out MAY change every SHIFT cycle; they SHALL hold their values from done until the next accepted start.

Reset
REQ-025 rst high at an edge SHALL force IDLE, out=0, carry_out=0, busy=0, done=0, remaining=0, in any state including mid-SHIFT; rst SHALL take priority over start.
REQ-026 The first start after rst deassertion SHALL be accepted normally.

Configuration
REQ-027 Macro SHIFT_SEQ_ZERO_FLAG_EN: when defined, the block SHALL add output zero (1 bit), registered, equal to (out==0) and updated on every edge that updates out, reset to 1.
REQ-028 Without SHIFT_SEQ_ZERO_FLAG_EN, the port zero and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 SHL, in=0x81, carry_in=0, count=1 -> done after edge 1, out=0x02, carry_out=1.
REQ-030 ROR, in=0x01, carry_in=1, count=2 -> busy for 2 cycles, done after edge 2, out=0xC0, carry_out=0.
REQ-031 count=0, in=0x5A, carry_in=1, any mode -> busy never high, done after edge 0, out=0x5A, carry_out=1.
REQ-032 ROL, in=0x80, carry_in=0, count=7 -> done after edge 7, out=0x20, carry_out=0; a second start pulsed at edge 3 SHALL be ignored.
REQ-033 rst at edge 3 of a count=7 operation -> next cycle out=0x00, carry_out=0, busy=0, done=0, no done pulse afterwards.
REQ-034 Back-to-back: start held high through DONE with SHR, in=0x01, count=1 -> second done exactly 2 cycles after the first, out=0x00, carry_out=1, and with SHIFT_SEQ_ZERO_FLAG_EN defined zero=1.

Source files
------------

// File: rtl/shift_seq.sv
// shift_seq: multi-cycle shifter/rotator sequencer.
// An accepted start loads the operand and the carry. The block then performs
// `count` single-bit steps (SHL, SHR, ROL or ROR through carry), one per clock
// edge, and then pulses done for one cycle.
//
// Parameters:
//   WIDTH     datapath width (power of two, >= 4)
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   start     request a new operation (accepted in IDLE or DONE)
//   mode      00 SHL, 01 SHR, 10 ROL through carry, 11 ROR through carry
//   count     number of single-bit steps, 0..WIDTH-1
//   in        operand
//   carry_in  initial carry
//   out       working/result register
//   carry_out working/result carry register
//   busy      high while shifting
//   done      one-cycle pulse when the result is valid
//   zero      (only with SHIFT_SEQ_ZERO_FLAG_EN) registered out==0 flag
//
// Optional feature macro: SHIFT_SEQ_ZERO_FLAG_EN adds the zero output.
module shift_seq #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CW-1:0]    count,
    input  logic [WIDTH-1:0] in,
    input  logic             carry_in,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             busy,
    output logic             done
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               carry_q, carry_d;
    logic [1:0]         mode_q, mode_d;
    logic [CW-1:0]      rem_q, rem_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            carry_q <= 1'b0;
            mode_q  <= 2'b00;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state and datapath step
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        carry_d = carry_q;
        mode_d  = mode_q;
        rem_d   = rem_q;

        case (state_q)
            ST_SHIFT: begin
                case (mode_q)
                    2'b00: begin
                        carry_d = out_q[WIDTH-1];
                        out_d   = {out_q[WIDTH-2:0], 1'b0};
                    end
                    2'b01: begin
                        carry_d = out_q[0];
                        out_d   = {1'b0, out_q[WIDTH-1:1]};
                    end
                    2'b10: begin
                        carry_d = out_q[WIDTH-1];
                        out_d   = {out_q[WIDTH-2:0], carry_q};
                    end
                    default: begin
                        carry_d = out_q[0];
                        out_d   = {carry_q, out_q[WIDTH-1:1]};
                    end
                endcase
                rem_d = rem_q - CW'(1);
                if (rem_q == CW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept a new operation; DONE falls back
                // to IDLE otherwise, holding the result registers.
                if (start) begin
                    out_d   = in;
                    carry_d = carry_in;
                    mode_d  = mode;
                    rem_d   = count;
                    state_d = (count == '0) ? ST_DONE : ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    assign out       = out_q;
    assign carry_out = carry_q;
    assign busy      = (state_q == ST_SHIFT);
    assign done      = (state_q == ST_DONE);

`ifdef SHIFT_SEQ_ZERO_FLAG_EN
    logic zero_q;

    // out_d equals out_q on edges that leave out unchanged, so this tracks out.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b1;
        end else begin
            zero_q <= (out_d == '0);
        end
    end

    assign zero = zero_q;
`endif

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq (WIDTH = 8).
module tb_shift_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic [2:0] count;
    logic [7:0] din;
    logic       carry_in;
    logic [7:0] out;
    logic       carry_out;
    logic       busy;
    logic       done;
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
    logic       zero;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    shift_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .count     (count),
        .in        (din),
        .carry_in  (carry_in),
        .out       (out),
        .carry_out (carry_out),
        .busy      (busy),
        .done      (done)
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
        ,
        .zero      (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("mismatch in %s", tag);
        end
    endtask

    // Reference: the whole N-step operation as one shift/rotate.
    // Rotations through carry are a rotate of the 9-bit value {carry, data}.
    function automatic logic [8:0] model(input logic [1:0] m, input logic [7:0] d,
                                         input logic c, input int n);
        logic [15:0] p;
        logic [8:0]  v;
        v = {c, d};
        if (n == 0) return v;
        case (m)
            2'b00: begin
                p = 16'(d) << n;
                return {p[8], p[7:0]};
            end
            2'b01: begin
                p = {d, 8'h00} >> n;
                return {p[7], p[15:8]};
            end
            2'b10:   return (v << n) | (v >> (9 - n));
            default: return (v >> n) | (v << (9 - n));
        endcase
    endfunction

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_result(input string tag, input logic [8:0] exp);
        chk({tag, ".out"}, 32'(out), 32'(exp[7:0]));
        chk({tag, ".carry"}, 32'(carry_out), 32'(exp[8]));
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
        chk({tag, ".zero"}, 32'(zero), 32'(exp[7:0] == 8'h00));
`endif
    endtask

    // Start one operation, scramble inputs while it runs, optionally pulse a
    // second start at edge pulse_at, then check latency, result and hold.
    task automatic run_op(input string tag, input logic [1:0] m, input logic [7:0] d,
                          input logic c, input int n, input int pulse_at,
                          output logic [8:0] res);
        int lat;
        bit seen;
        res = model(m, d, c, n);
        mode = m; din = d; carry_in = c; count = 3'(n); start = 1'b1;
        edge_wait();
        start = 1'b0;
        lat = 0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                chk({tag, ".busy_run"}, 32'(busy), 32'd1);
                start    = (lat + 1 == pulse_at);
                mode     = 2'($urandom);
                din      = 8'($urandom);
                carry_in = 1'($urandom);
                count    = 3'($urandom);
                edge_wait();
                lat++;
            end
        end
        start = 1'b0;
        chk({tag, ".done_seen"}, 32'(seen), 32'd1);
        chk({tag, ".latency"}, 32'(lat), 32'(n));
        chk({tag, ".busy_done"}, 32'(busy), 32'd0);
        chk_result(tag, res);
        edge_wait();
        chk({tag, ".done_drop"}, 32'(done), 32'd0);
        chk({tag, ".busy_idle"}, 32'(busy), 32'd0);
        chk_result({tag, ".hold"}, res);
    endtask

    initial begin
        logic [8:0] r;
        bit         dpulse;
        rst = 1'b1; start = 1'b0; mode = 2'b00; count = 3'd0; din = 8'h00; carry_in = 1'b0;

        // Reset state
        edge_wait();
        edge_wait();
        rst = 1'b0;
        chk("reset.out", 32'(out), 32'h0);
        chk("reset.carry", 32'(carry_out), 32'h0);
        chk("reset.busy", 32'(busy), 32'h0);
        chk("reset.done", 32'(done), 32'h0);
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
        chk("reset.zero", 32'(zero), 32'h1);
`endif

        // SHL 0x81 by 1
        run_op("shl1", 2'b00, 8'h81, 1'b0, 1, -1, r);
        chk("shl1.const", 32'(r), 32'h102);

        // ROR 0x01 carry 1 by 2
        run_op("ror2", 2'b11, 8'h01, 1'b1, 2, -1, r);
        chk("ror2.const", 32'(r), 32'h0C0);

        // count = 0 in every mode: immediate done, operand passes through
        for (int m = 0; m < 4; m++) begin
            run_op($sformatf("cnt0_m%0d", m), 2'(m), 8'h5A, 1'b1, 0, -1, r);
        end

        // ROL 0x80 by 7 with an ignored start at edge 3
        run_op("rol7", 2'b10, 8'h80, 1'b0, 7, 3, r);
        chk("rol7.const", 32'(r), 32'h020);

        // Reset mid-operation
        mode = 2'b10; din = 8'hA5; carry_in = 1'b1; count = 3'd7; start = 1'b1;
        edge_wait();
        start = 1'b0;
        edge_wait();
        edge_wait();
        rst = 1'b1;
        edge_wait();
        rst = 1'b0;
        chk("midrst.out", 32'(out), 32'h0);
        chk("midrst.carry", 32'(carry_out), 32'h0);
        chk("midrst.busy", 32'(busy), 32'h0);
        chk("midrst.done", 32'(done), 32'h0);
        dpulse = 1'b0;
        for (int k = 0; k < 10; k++) begin
            edge_wait();
            if (done || busy) dpulse = 1'b1;
        end
        chk("midrst.quiet", 32'(dpulse), 32'h0);

        // First start after reset is accepted
        run_op("postrst", 2'b01, 8'hF0, 1'b0, 3, -1, r);

        // Back-to-back: start held through DONE, SHR 0x01 by 1
        mode = 2'b01; din = 8'h01; carry_in = 1'b0; count = 3'd1; start = 1'b1;
        edge_wait();
        chk("b2b.busy0", 32'(busy), 32'h1);
        edge_wait();
        chk("b2b.done1", 32'(done), 32'h1);
        chk_result("b2b.first", 9'h100);
        edge_wait();
        chk("b2b.gap_done", 32'(done), 32'h0);
        chk("b2b.gap_busy", 32'(busy), 32'h1);
        start = 1'b0;
        edge_wait();
        chk("b2b.done2", 32'(done), 32'h1);
        chk_result("b2b.second", 9'h100);
        edge_wait();
        chk("b2b.idle", 32'(done), 32'h0);

        // Randomized operations against the reference model
        for (int t = 0; t < 40; t++) begin
            int n;
            int p;
            n = int'($urandom_range(0, 7));
            p = (n >= 2 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, n - 1)) : -1;
            run_op($sformatf("rnd%0d", t), 2'($urandom), 8'($urandom), 1'($urandom), n, p, r);
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) edge_wait();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
